mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester and the load/store requester of the core.
- Accepts one transaction at a time.
- Drives a registered request/grant/response handshake toward memory and returns the read data, or the write acknowledge, to the requester that owns the transaction.
- Sits between the core's fetch and load/store ports and the external memory controller, replacing the separate fetch and data clock strobes with explicit handshakes.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter_arb_pick.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the unified memory-port arbiter: FSM state encoding,
// transaction owner IDs and a small helper used by the round-robin pick.
// Optional feature macro (consumed by the pick logic): MEM_ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_FETCH = 1'b0,
    ARB_OWNER_DATA  = 1'b1
  } arb_owner_t;

  function automatic arb_owner_t other_owner(input arb_owner_t owner);
    return (owner == ARB_OWNER_FETCH) ? ARB_OWNER_DATA : ARB_OWNER_FETCH;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Request/grant/response bus toward the external memory controller.
//   master : arbiter side (drives m_req/m_we/m_addr/m_wdata/m_be)
//   slave  : memory side  (drives m_gnt/m_rvalid/m_rdata)
interface mem_port_arbiter_if #(
  parameter int W = 32
);
  localparam int BE_W = W / 8;

  logic            m_req;
  logic            m_we;
  logic [W-1:0]    m_addr;
  logic [W-1:0]    m_wdata;
  logic [BE_W-1:0] m_be;
  logic            m_gnt;
  logic            m_rvalid;
  logic [W-1:0]    m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_gnt, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// mem_port_arbiter_arb_pick
// Combinational winner selection between the fetch and data requesters.
//   i_if_req, i_d_req : pending requests
//   i_last_owner      : owner of the most recently completed transaction
//   o_valid           : at least one request pending
//   o_winner          : requester to grant
// Macro MEM_ARB_ROUND_ROBIN_EN: when defined, a conflict goes to the requester
// that did not own the last transaction; otherwise data always beats fetch.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_if_req,
  input  logic       i_d_req,
  input  arb_owner_t i_last_owner,
  output logic       o_valid,
  output arb_owner_t o_winner
);

  always_comb begin
    o_valid  = i_if_req | i_d_req;
    o_winner = ARB_OWNER_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_if_req && i_d_req) begin
      o_winner = other_owner(i_last_owner);
    end else if (i_d_req) begin
      o_winner = ARB_OWNER_DATA;
    end
`else
    if (i_d_req) begin
      o_winner = ARB_OWNER_DATA;
    end
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // last_owner is tracked by the top either way; fixed priority ignores it.
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store. One
// transaction in flight; registered request toward memory, one-cycle rvalid
// pulse back to the owning requester.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-low reset
//   i_if_* / o_if_*      : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   i_d_* / o_d_*        : load/store requester
//   mem (master modport) : memory controller bus
//   o_busy               : state is not IDLE
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W    = 32,
  parameter int BE_W = W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_if_req,
  input  logic [W-1:0]      i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [W-1:0]      o_if_rdata,

  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [W-1:0]      i_d_addr,
  input  logic [W-1:0]      i_d_wdata,
  input  logic [BE_W-1:0]   i_d_be,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [W-1:0]      o_d_rdata,

  mem_port_arbiter_if.master mem,

  output logic              o_busy
);

  arb_state_t      r_state;
  arb_owner_t      r_owner;
  arb_owner_t      r_last_owner;
  logic            r_m_req;
  logic            r_m_we;
  logic [W-1:0]    r_m_addr;
  logic [W-1:0]    r_m_wdata;
  logic [BE_W-1:0] r_m_be;
  logic            r_if_rvalid;
  logic            r_d_rvalid;
  logic [W-1:0]    r_if_rdata;
  logic [W-1:0]    r_d_rdata;

  logic            w_pick_valid;
  arb_owner_t      w_winner;
  logic            w_grant;
  logic            w_resp_now;

  mem_port_arbiter_arb_pick u_pick (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_winner     (w_winner)
  );

  assign w_grant  = (r_state == ARB_IDLE) && w_pick_valid;
  assign o_if_gnt = w_grant && (w_winner == ARB_OWNER_FETCH);
  assign o_d_gnt  = w_grant && (w_winner == ARB_OWNER_DATA);

  // Response data is captured on the edge that enters RESP, so rvalid is
  // already high during the RESP cycle itself.
  assign w_resp_now = ((r_state == ARB_REQ) && mem.m_gnt && mem.m_rvalid) ||
                      ((r_state == ARB_WAIT) && mem.m_rvalid);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_OWNER_FETCH;
      r_last_owner <= ARB_OWNER_FETCH;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_be       <= '0;
      r_if_rvalid  <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;

      if (w_resp_now) begin
        if (r_owner == ARB_OWNER_FETCH) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem.m_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_m_we ? '0 : mem.m_rdata;
        end
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_m_req <= 1'b1;
            r_state <= ARB_REQ;
            if (w_winner == ARB_OWNER_DATA) begin
              r_m_we    <= i_d_we;
              r_m_addr  <= i_d_addr;
              r_m_wdata <= i_d_wdata;
              r_m_be    <= i_d_we ? i_d_be : '1;
            end else begin
              r_m_we    <= 1'b0;
              r_m_addr  <= i_if_addr;
              r_m_wdata <= '0;
              r_m_be    <= '1;
            end
          end
        end
        ARB_REQ: begin
          if (mem.m_gnt) begin
            r_m_req <= 1'b0;
            r_state <= mem.m_rvalid ? ARB_RESP : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem.m_rvalid) begin
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          r_last_owner <= r_owner;
          r_state      <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign mem.m_req   = r_m_req;
  assign mem.m_we    = r_m_we;
  assign mem.m_addr  = r_m_addr;
  assign mem.m_wdata = r_m_wdata;
  assign mem.m_be    = r_m_be;

  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_d_rdata   = r_d_rdata;
  assign o_busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter; memory side is driven by hand per cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter_if #(.W(32)) mem_bus ();

  mem_port_arbiter #(.W(32), .BE_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .i_d_be      (d_be),
    .o_d_gnt     (d_gnt),
    .o_d_rvalid  (d_rvalid),
    .o_d_rdata   (d_rdata),
    .mem         (mem_bus.master),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mem_drive(input logic gnt, input logic rv, input logic [31:0] rd);
    mem_bus.m_gnt    = gnt;
    mem_bus.m_rvalid = rv;
    mem_bus.m_rdata  = rd;
  endtask

  // Both requesters held (fetch 0x80, load 0x200); zero-wait memory.
  task automatic conflict_txn(input logic exp_data, input logic [31:0] rd);
    #1;
    check_eq("cf_if_gnt", {31'b0, if_gnt}, {31'b0, !exp_data});
    check_eq("cf_d_gnt", {31'b0, d_gnt}, {31'b0, exp_data});
    tick();
    #1;
    check_eq("cf_m_req", {31'b0, mem_bus.m_req}, 32'd1);
    check_eq("cf_m_addr", mem_bus.m_addr, exp_data ? 32'h200 : 32'h80);
    check_eq("cf_m_be", {28'b0, mem_bus.m_be}, 32'hF);
    mem_drive(1'b1, 1'b1, rd);
    tick();
    #1;
    check_eq("cf_if_rvalid", {31'b0, if_rvalid}, {31'b0, !exp_data});
    check_eq("cf_d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_data});
    check_eq("cf_rdata", exp_data ? d_rdata : if_rdata, rd);
    mem_drive(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #1;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_m_req", {31'b0, mem_bus.m_req}, 32'd0);
    check_eq("rst_m_be", {28'b0, mem_bus.m_be}, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    rst = 1'b1;
    tick();

    // Fetch-only, zero-wait memory with combined m_gnt/m_rvalid.
    if_req = 1; if_addr = 32'h40;
    mem_drive(1'b1, 1'b1, 32'h2402_0005);
    #1;
    check_eq("f_if_gnt", {31'b0, if_gnt}, 32'd1);
    check_eq("f_d_gnt", {31'b0, d_gnt}, 32'd0);
    tick();
    if_req = 0;
    #1;
    check_eq("f_m_req", {31'b0, mem_bus.m_req}, 32'd1);
    check_eq("f_m_addr", mem_bus.m_addr, 32'h40);
    check_eq("f_m_we", {31'b0, mem_bus.m_we}, 32'd0);
    check_eq("f_m_be", {28'b0, mem_bus.m_be}, 32'hF);
    check_eq("f_busy", {31'b0, busy}, 32'd1);
    tick();
    #1;
    check_eq("f_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    check_eq("f_if_rdata", if_rdata, 32'h2402_0005);
    check_eq("f_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    mem_drive(1'b0, 1'b0, 32'h0);
    tick();
    #1;
    check_eq("f_if_rvalid_end", {31'b0, if_rvalid}, 32'd0);
    check_eq("f_busy_end", {31'b0, busy}, 32'd0);

    // Spurious m_rvalid in IDLE.
    mem_drive(1'b0, 1'b1, 32'h0000_1234);
    tick();
    tick();
    #1;
    check_eq("sp_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_eq("sp_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check_eq("sp_busy", {31'b0, busy}, 32'd0);
    check_eq("sp_if_rdata", if_rdata, 32'h2402_0005);
    mem_drive(1'b0, 1'b0, 32'h0);
    tick();

    // Store with 3 cycles of m_gnt delay and m_rvalid 2 cycles later.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    #1;
    check_eq("s_d_gnt", {31'b0, d_gnt}, 32'd1);
    check_eq("s_if_gnt", {31'b0, if_gnt}, 32'd0);
    tick();
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      // m_rvalid without m_gnt in REQ must be ignored.
      mem_drive(1'b0, (i == 1), 32'h5555_5555);
      #1;
      check_eq("s_m_req", {31'b0, mem_bus.m_req}, 32'd1);
      check_eq("s_m_addr", mem_bus.m_addr, 32'h100);
      check_eq("s_m_wdata", mem_bus.m_wdata, 32'hDEAD_BEEF);
      check_eq("s_m_be", {28'b0, mem_bus.m_be}, 32'h3);
      check_eq("s_m_we", {31'b0, mem_bus.m_we}, 32'd1);
      tick();
    end
    mem_drive(1'b1, 1'b0, 32'h0);
    tick();
    mem_drive(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("s_wait_m_req", {31'b0, mem_bus.m_req}, 32'd0);
    check_eq("s_wait_busy", {31'b0, busy}, 32'd1);
    check_eq("s_wait_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    tick();
    mem_drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    #1;
    check_eq("s_wait2_busy", {31'b0, busy}, 32'd1);
    tick();
    mem_drive(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("s_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    check_eq("s_d_rdata", d_rdata, 32'h0);
    check_eq("s_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_eq("s_resp_busy", {31'b0, busy}, 32'd1);
    tick();
    #1;
    check_eq("s_d_rvalid_end", {31'b0, d_rvalid}, 32'd0);
    check_eq("s_busy_end", {31'b0, busy}, 32'd0);

    // Simultaneous requests: load 0x200 vs fetch 0x80.
    d_we = 0; d_addr = 32'h200; d_be = 4'h0;
    if_addr = 32'h80;
    if_req = 1; d_req = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // The store above makes data the last owner, so fetch wins first.
    conflict_txn(1'b0, 32'h1111_0001);
    conflict_txn(1'b1, 32'h1111_0002);
    conflict_txn(1'b0, 32'h1111_0003);
    conflict_txn(1'b1, 32'h1111_0004);
    if_req = 0; d_req = 0;
`else
    conflict_txn(1'b1, 32'h1111_0001);
    d_req = 0;
    conflict_txn(1'b0, 32'h1111_0002);
    if_req = 0;
    #1;
    check_eq("cf_d_rdata_hold", d_rdata, 32'h1111_0001);
`endif
    tick();

    // Reset during WAIT.
    if_req = 1; if_addr = 32'h300;
    tick();
    if_req = 0;
    mem_drive(1'b1, 1'b0, 32'h0);
    tick();
    mem_drive(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rw_busy_wait", {31'b0, busy}, 32'd1);
    check_eq("rw_m_addr_wait", mem_bus.m_addr, 32'h300);
    rst = 0;
    tick();
    #1;
    check_eq("rw_busy", {31'b0, busy}, 32'd0);
    check_eq("rw_m_req", {31'b0, mem_bus.m_req}, 32'd0);
    check_eq("rw_m_addr", mem_bus.m_addr, 32'd0);
    check_eq("rw_m_be", {28'b0, mem_bus.m_be}, 32'd0);
    check_eq("rw_if_rdata", if_rdata, 32'd0);
    check_eq("rw_d_rdata", d_rdata, 32'd0);
    rst = 1;
    mem_drive(1'b0, 1'b1, 32'h0000_0BAD);
    tick();
    #1;
    check_eq("rw_late_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check_eq("rw_late_busy", {31'b0, busy}, 32'd0);
    mem_drive(1'b0, 1'b0, 32'h0);
    tick();
    #1;
    check_eq("rw_late_if_rvalid2", {31'b0, if_rvalid}, 32'd0);
    if_req = 1; if_addr = 32'h44;
    #1;
    check_eq("rw_if_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 0;
    #1;
    check_eq("rw_m_addr_new", mem_bus.m_addr, 32'h44);
    mem_drive(1'b1, 1'b1, 32'h0000_0077);
    tick();
    mem_drive(1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rw_if_rvalid_new", {31'b0, if_rvalid}, 32'd1);
    check_eq("rw_if_rdata_new", if_rdata, 32'h77);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
